mod_down_timer: RTL

- Programmable modulus down-counter/timer; the decrementing counterpart to the team's free-running modulus up-counter.
- Loads a runtime modulus M and counts M-1 down to 0.
- At 0 it emits a one-cycle terminal-count pulse, then either reloads (periodic) or stops (one-shot).
- Used as the tick/timeout generator beside up-counters in the datapath; a borrow output allows cascading.

---
 rtl/mod_counter_pkg.sv | 6 +
 rtl/mod_down_timer.sv | 66 ++++++
 2 files changed

// File: rtl/mod_counter_pkg.sv
// mod_counter_pkg: shared state encoding and defaults for the modulus counter family
package mod_counter_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_MOD   = 8;
endpackage

// File: rtl/mod_down_timer.sv
// mod_down_timer: programmable modulus down-counter with terminal-count pulse and borrow
module mod_down_timer
  import mod_counter_pkg::*;
#(
  parameter int WIDTH       = mod_counter_pkg::DEFAULT_WIDTH,
  parameter int DEFAULT_MOD = mod_counter_pkg::DEFAULT_MOD
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             borrow
);
  state_t           state_d, state_q;
  logic [WIDTH-1:0] count_d, count_q, mod_d, mod_q, lv;
  logic             tc_d, tc_q, go;
  assign lv = (load_val == '0) ? WIDTH'(1) : load_val;
  assign go = start && state_q != RUN;
  // next state: stop beats load/start, which beat counting; 0 is handled before any decrement
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    mod_d   = mod_q;
    tc_d    = 1'b0;
    if (stop) state_d = IDLE;
    else if (load || go) begin
      if (load) begin
        mod_d   = lv;
        count_d = lv - 1'b1;
      end else count_d = mod_q - 1'b1;
      if (go) state_d = RUN;
    end else if (state_q == RUN && en) begin
      if (count_q != '0) count_d = count_q - 1'b1;
      else begin
        tc_d = 1'b1;
        if (periodic) count_d = mod_q - 1'b1;
        else state_d = DONE;
      end
    end
  end
  // state, modulus, count and tc registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      mod_q   <= WIDTH'(DEFAULT_MOD);
      count_q <= WIDTH'(DEFAULT_MOD - 1);
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mod_q   <= mod_d;
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end
  assign count  = count_q;
  assign busy   = state_q == RUN;
  assign tc     = tc_q;
  assign borrow = count_q == '0 && busy && en;
endmodule
